// File: rtl/mem_cmd_pkg.sv
// Shared types and constants for the byte-stream memory command initiator.
package mem_cmd_pkg;

  // Command opcodes carried in the first byte of every command.
  localparam logic [7:0] OP_WRITE = 8'hA5;
  localparam logic [7:0] OP_READ  = 8'h5A;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    WAIT_VALID,
    SEND
  } state_e;

  // True for the two opcodes the controller understands.
  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/mem_cmd_ctrl.sv
// Byte-stream command initiator: assembles write/read commands from UART RX
// bytes, strobes the word-wide memory port, and streams read words back to
// UART TX most-significant byte first.
module mem_cmd_ctrl
  import mem_cmd_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MEM_DEPTH  = 64,
  parameter  int unsigned RD_TIMEOUT = 4,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  // UART RX byte stream
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  // UART TX byte stream
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  // Memory port
  output logic                  write_En,
  output logic                  read_En,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] Data_in,
  input  logic [DATA_WIDTH-1:0] Data_out,
  input  logic                  Valid_out,
  // Status
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
  localparam int unsigned TO_W   = $clog2(RD_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [TO_W-1:0]  LAST_WAIT = TO_W'(RD_TIMEOUT - 1);

  state_e                state_q;
  logic                  is_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_in_q;
  logic [DATA_WIDTH-1:0] tx_shift_q;
  // One byte counter serves both the RX assembler and the TX serializer.
  logic [CNT_W-1:0]      cnt_q;
  logic [TO_W-1:0]       to_cnt_q;
  logic                  rx_ready_q;
  logic                  tx_valid_q;
  logic                  write_en_q;
  logic                  read_en_q;
  logic                  cmd_err_q;

  logic rx_fire;
  logic tx_fire;

  assign rx_fire = rx_valid && rx_ready_q;
  assign tx_fire = tx_valid_q && tx_ready;

  // Command FSM with all handshake and strobe outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_in_q  <= '0;
      tx_shift_q <= '0;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      // Strobes and the error flag are single-cycle pulses.
      write_en_q <= 1'b0;
      read_en_q  <= 1'b0;
      cmd_err_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (rx_fire) begin
            if (is_opcode(rx_data)) begin
              is_write_q <= (rx_data == OP_WRITE);
              state_q    <= GET_ADDR;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end

        GET_ADDR: begin
          if (rx_fire) begin
            // Upper address bits beyond the memory depth are dropped.
            addr_q <= rx_data[ADDR_WIDTH-1:0];
            if (is_write_q) begin
              cnt_q   <= '0;
              state_q <= GET_DATA;
            end else begin
              rx_ready_q <= 1'b0;
              read_en_q  <= 1'b1;
              state_q    <= READ;
            end
          end
        end

        GET_DATA: begin
          if (rx_fire) begin
            data_in_q <= {data_in_q[DATA_WIDTH-9:0], rx_data};
            cnt_q     <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BYTE) begin
              rx_ready_q <= 1'b0;
              write_en_q <= 1'b1;
              state_q    <= WRITE;
            end
          end
        end

        WRITE: begin
          rx_ready_q <= 1'b1;
          state_q    <= IDLE;
        end

        READ: begin
          to_cnt_q <= '0;
          state_q  <= WAIT_VALID;
        end

        WAIT_VALID: begin
          if (Valid_out) begin
            tx_shift_q <= Data_out;
            cnt_q      <= '0;
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end else if (to_cnt_q == LAST_WAIT) begin
            // Memory never answered: give up and report it.
            cmd_err_q  <= 1'b1;
            rx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        SEND: begin
          if (tx_fire) begin
            tx_shift_q <= tx_shift_q << 8;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BYTE) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end

        default: begin
          tx_valid_q <= 1'b0;
          rx_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_shift_q[DATA_WIDTH-1 -: 8];
  assign write_En = write_en_q;
  assign read_En  = read_en_q;
  assign Address  = addr_q;
  assign Data_in  = data_in_q;
  assign cmd_err  = cmd_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Self-checking bench for mem_cmd_ctrl: a behavioural memory responder plus a
// reference memory image that predicts every write and every returned byte.
module tb_mem_cmd_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int NB    = DW / 8;
  localparam int RDT   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          write_En;
  logic          read_En;
  logic [AW-1:0] Address;
  logic [DW-1:0] Data_in;
  logic [DW-1:0] Data_out;
  logic          Valid_out;
  logic          busy;
  logic          cmd_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_cmd_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .write_En (write_En),
    .read_En  (read_En),
    .Address  (Address),
    .Data_in  (Data_in),
    .Data_out (Data_out),
    .Valid_out(Valid_out),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  // Memory block stand-in and the independent expected image.
  logic [DW-1:0] mem_model [DEPTH];
  logic [DW-1:0] ref_mem   [DEPTH];
  logic          rd_seen = 1'b0;
  logic [AW-1:0] rd_addr;
  bit            resp_en = 1'b1;

  // Observed traffic.
  int            wr_cnt  = 0;
  int            rd_cnt  = 0;
  int            err_cnt = 0;
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [7:0]    txq [$];
  bit            tx_seen   = 1'b0;
  bit            hold_pend = 1'b0;
  logic [7:0]    hold_data;

  // Memory stand-in: writes land, reads answer one cycle after read_En.
  always @(negedge clk) begin
    if (write_En) mem_model[Address] = Data_in;
    rd_seen = read_En;
    rd_addr = Address;
  end

  always @(posedge clk) begin
    #1;
    Valid_out = rd_seen && resp_en;
    Data_out  = Valid_out ? mem_model[rd_addr] : DW'($urandom);
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (write_En) begin
      wr_cnt++;
      wr_addr_q.push_back(Address);
      wr_data_q.push_back(Data_in);
    end
    if (read_En) rd_cnt++;
    if (write_En || read_En) begin
      checks++;
      if (write_En && read_En) begin
        failures++;
        $display("FAIL strobe_overlap: write_En=%b read_En=%b, required never both", write_En,
                 read_En);
      end
    end
    if (cmd_err) err_cnt++;
    if (tx_valid) tx_seen = 1'b1;
    if (tx_valid && tx_ready && !rst) txq.push_back(tx_data);
    if (hold_pend) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== hold_data) begin
        failures++;
        $display("FAIL tx_hold: tx_valid=%b tx_data=%h, required 1 and %h", tx_valid, tx_data,
                 hold_data);
      end
    end
    hold_pend = tx_valid && !tx_ready && !rst;
    hold_data = tx_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL rx_accept: rx_ready stayed %b for %0d cycles, required 1", rx_ready, n);
    end
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [DW-1:0] d);
    int w0 = wr_cnt;
    send_byte(8'hA5);
    send_byte(a);
    for (int i = 0; i < NB; i++) send_byte(d[DW-1-8*i -: 8]);
    // Cycle after the last data byte: the strobe cycle.
    chk("wr_strobe", DW'(write_En), DW'(1));
    chk("wr_rx_ready_low", DW'(rx_ready), DW'(0));
    chk("wr_busy", DW'(busy), DW'(1));
    step();
    chk("wr_strobe_end", DW'(write_En), DW'(0));
    chk("wr_rx_ready_back", DW'(rx_ready), DW'(1));
    chk("wr_idle", DW'(busy), DW'(0));
    chk("wr_count", DW'(wr_cnt), DW'(w0 + 1));
    chk("wr_addr_hold", DW'(Address), DW'(a[AW-1:0]));
    if (wr_addr_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL wr_seen: no write_En observed, required 1");
    end else begin
      chk("wr_addr", DW'(wr_addr_q.pop_front()), DW'(a[AW-1:0]));
      chk("wr_data", wr_data_q.pop_front(), d);
    end
    ref_mem[a[AW-1:0]] = d;
  endtask

  task automatic do_read(input logic [7:0] a, input int gap);
    logic [DW-1:0] exp = ref_mem[a[AW-1:0]];
    txq.delete();
    tx_ready = 1'b0;
    send_byte(8'h5A);
    send_byte(a);
    chk("rd_strobe", DW'(read_En), DW'(1));
    chk("rd_rx_ready_low", DW'(rx_ready), DW'(0));
    step();
    step();
    chk("rd_first_valid", DW'(tx_valid), DW'(1));
    chk("rd_first_byte", DW'(tx_data), DW'(exp[DW-1 -: 8]));
    for (int i = 0; i < NB; i++) begin
      repeat (gap) step();
      chk("rd_tx_valid", DW'(tx_valid), DW'(1));
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    chk("rd_tx_done", DW'(tx_valid), DW'(0));
    chk("rd_idle", DW'(busy), DW'(0));
    chk("rd_rx_ready", DW'(rx_ready), DW'(1));
    step();
    chk("rd_byte_count", DW'(txq.size()), DW'(NB));
    for (int i = 0; i < NB && i < txq.size(); i++)
      chk("rd_byte", DW'(txq[i]), DW'(exp[DW-1-8*i -: 8]));
  endtask

  task automatic check_reset_state();
    chk("rst_rx_ready", DW'(rx_ready), DW'(1));
    chk("rst_tx_valid", DW'(tx_valid), DW'(0));
    chk("rst_tx_data", DW'(tx_data), DW'(0));
    chk("rst_write_En", DW'(write_En), DW'(0));
    chk("rst_read_En", DW'(read_En), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_cmd_err", DW'(cmd_err), DW'(0));
    chk("rst_Address", DW'(Address), DW'(0));
    chk("rst_Data_in", Data_in, DW'(0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state();
  endtask

  task automatic test_write();
    do_write(8'h03, 32'hDEADBEEF);
  endtask

  task automatic test_read_back();
    do_read(8'h03, 0);
  endtask

  task automatic test_backpressure();
    do_read(8'h03, 3);
  endtask

  task automatic test_bad_opcode();
    for (int k = 0; k < 3; k++) begin
      logic [7:0] b = (k == 0) ? 8'h11 : 8'($urandom);
      int w0 = wr_cnt;
      int r0 = rd_cnt;
      int e0;
      while (b == 8'hA5 || b == 8'h5A) b = 8'($urandom);
      send_byte(b);
      e0 = err_cnt;
      chk("bad_cmd_err", DW'(cmd_err), DW'(1));
      chk("bad_busy", DW'(busy), DW'(0));
      chk("bad_rx_ready", DW'(rx_ready), DW'(1));
      step();
      chk("bad_cmd_err_pulse", DW'(cmd_err), DW'(0));
      chk("bad_err_count", DW'(err_cnt), DW'(e0 + 1));
      chk("bad_no_write", DW'(wr_cnt), DW'(w0));
      chk("bad_no_read", DW'(rd_cnt), DW'(r0));
    end
    do_write(8'h15, DW'($urandom));
    do_read(8'h15, 1);
  endtask

  task automatic test_timeout();
    int k = 0;
    resp_en = 1'b0;
    tx_ready = 1'b1;
    send_byte(8'h5A);
    send_byte(8'h21);
    chk("to_strobe", DW'(read_En), DW'(1));
    tx_seen = 1'b0;
    while (cmd_err !== 1'b1 && k < 12) begin
      step();
      k++;
    end
    chk("to_latency", DW'(k), DW'(RDT + 1));
    chk("to_idle", DW'(busy), DW'(0));
    chk("to_rx_ready", DW'(rx_ready), DW'(1));
    step();
    chk("to_err_pulse", DW'(cmd_err), DW'(0));
    chk("to_no_tx", DW'(tx_seen), DW'(0));
    tx_ready = 1'b0;
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    int w0 = wr_cnt;
    logic [DW-1:0] d = DW'($urandom);
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state();
    step();
    step();
    chk("rmw_no_write", DW'(wr_cnt), DW'(w0));
    do_write(8'h07, d);
    do_read(8'h07, 1);
  endtask

  task automatic test_reset_mid_send();
    tx_ready = 1'b0;
    send_byte(8'h5A);
    send_byte(8'h07);
    step();
    step();
    chk("rms_tx_valid_before", DW'(tx_valid), DW'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rms_tx_valid_drop", DW'(tx_valid), DW'(0));
    chk("rms_busy", DW'(busy), DW'(0));
    chk("rms_rx_ready", DW'(rx_ready), DW'(1));
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] a = 8'($urandom);
      do_write(a, DW'($urandom));
      do_read(8'($urandom_range(0, 255)), $urandom_range(0, 3));
      do_read(a, $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = '0;
      ref_mem[i]   = '0;
    end
    rst       = 1'b1;
    rx_data   = '0;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    Valid_out = 1'b0;
    Data_out  = '0;
    step();
    test_reset();
    test_write();
    test_read_back();
    test_backpressure();
    test_bad_opcode();
    test_timeout();
    test_reset_mid_write();
    test_reset_mid_send();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_cmd_ctrl.md
Name: mem_cmd_ctrl

Overview:
- Byte-stream command initiator that drives the word-wide memory block's write/read port.
- Accepts command bytes from the UART receive path and issues single-cycle write_En/read_En strobes with Address/Data_in.
- Captures Data_out when Valid_out is asserted and streams the read word back to the UART transmit path, MSB byte first.
- Sits between the UART RX/TX byte interfaces and the memory.

Parameters:
- DATA_WIDTH, 32, memory word width; must be a multiple of 8.
- MEM_DEPTH, 64, memory depth in words.
- ADDR_WIDTH, $clog2(MEM_DEPTH), localparam; memory address width.
- NBYTES, DATA_WIDTH/8, localparam; bytes per word.
- RD_TIMEOUT, 4, cycles to wait for Valid_out after read_En before flagging an error.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  command byte from UART RX.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  block accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
- tx_data  out  8  response byte to UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  TX accepts a byte; a byte transfers when tx_valid && tx_ready.
- write_En  out  1  memory write strobe.
- read_En  out  1  memory read strobe.
- Address  out  ADDR_WIDTH  memory address.
- Data_in  out  DATA_WIDTH  memory write data.
- Data_out  in  DATA_WIDTH  memory read data.
- Valid_out  in  1  memory read data valid.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  one-cycle pulse on a bad opcode or a read timeout.

Behaviour:
- Reset (rst=1 at a clock edge), from any state: state=IDLE. All outputs 0 except rx_ready=1. Byte counter, timeout counter and data shift registers all clear.
- Command format:
  - Byte0 opcode: 8'hA5 = write, 8'h5A = read.
  - Byte1 address: the low ADDR_WIDTH bits are used; upper bits are ignored.
  - Write only: NBYTES data bytes follow, MSB first.
- rx_ready=1 in IDLE, GET_ADDR and GET_DATA only. rx_valid is ignored in all other states; those bytes are lost.
- State machine:
  - IDLE: on byte accept, opcode A5 or 5A → GET_ADDR with the opcode latched. Any other value → pulse cmd_err next cycle, stay in IDLE.
  - GET_ADDR: on accept, latch Address. Write → GET_DATA with byte count=0. Read → READ.
  - GET_DATA: each accept does Data_in <= {Data_in[DATA_WIDTH-9:0], rx_data} and increments the count. The NBYTES-th accept → WRITE.
  - WRITE: write_En=1 for exactly one cycle, then IDLE. Address and Data_in stay stable through the strobe cycle.
  - READ: read_En=1 for exactly one cycle, then WAIT_VALID with the timeout counter at 0.
  - WAIT_VALID: when Valid_out=1, capture Data_out into the tx shift register and go to SEND with byte count=0. Otherwise increment the counter; when it reaches RD_TIMEOUT, pulse cmd_err and go to IDLE. Valid_out is expected one cycle after read_En.
  - SEND: tx_valid=1 and tx_data = shift register MSB byte. Both stay stable until tx_ready. On each handshake, shift left 8 bits and increment the count. After the NBYTES-th handshake, tx_valid=0 and state → IDLE.
- write_En and read_En are never high in the same cycle; each is high only in its own state.
- Latency, write: the last data byte is accepted at edge N; write_En is high in cycle N+1; rx_ready returns in cycle N+2.
- Latency, read: the address byte is accepted at edge N; read_En is high in cycle N+1; the first tx_valid appears in cycle N+3, given Valid_out in cycle N+2.
- Address and Data_in hold their last values after a command completes (they are not cleared).
- rst during SEND or WAIT_VALID aborts the transaction. tx_valid drops in the cycle following the reset edge.

Decomposition:
- Package mem_cmd_pkg:
  - state enum: IDLE, GET_ADDR, GET_DATA, WRITE, READ, WAIT_VALID, SEND.
  - Opcode constants OP_WRITE=8'hA5 and OP_READ=8'h5A.
- Single module; no sub-module needed. The RX assembler and TX serializer are shift registers sharing one byte counter.

Test Plan:
- Write: send A5, 03, DE, AD, BE, EF → exactly one write_En cycle with Address=3 and Data_in=32'hDEADBEEF; rx_ready low only during that cycle.
- Read-back: after the write above, send 5A, 03; memory returns Valid_out → tx bytes DE, AD, BE, EF in order, then busy=0.
- TX backpressure: read with tx_ready low for 3 cycles between bytes → tx_data/tx_valid held stable, no byte skipped or duplicated.
- Bad opcode 8'h11 → cmd_err pulses for 1 cycle, no memory strobe; a following A5 command completes normally.
- Read timeout: hold Valid_out at 0 after read_En → cmd_err pulses after 4 cycles, state returns to IDLE, tx_valid never rises.
- Reset mid-write: rst=1 after 2 data bytes → all outputs reset, no write_En; a fresh full write command then succeeds.
